// File: rtl/meter_pkg.sv
// Shared types and constants for the clock period meter.
package meter_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} meter_state_t;

    // One second of the 50 MHz board clock.
    localparam int unsigned DEFAULT_MAXCOUNT = 50_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous input with rise/fall pulse detection.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q_sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            sig_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = q_sync & ~sig_d;
    assign fall   = ~q_sync & sig_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in system clock cycles.
module clk_period_meter
    import meter_pkg::*;
#(
    parameter  int unsigned MAXCOUNT    = DEFAULT_MAXCOUNT,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned W           = $clog2(MAXCOUNT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         period_valid,
    output logic         timeout,
    output logic         locked
);

    localparam logic [W-1:0] MAX_W = W'(MAXCOUNT);
    localparam logic [W-1:0] ONE_W = W'(1);

    logic sig_s, rise, fall;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_async(sig_in),
        .q_sync (sig_s),
        .rise   (rise),
        .fall   (fall)
    );

    meter_state_t state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] high_cap_q, high_cap_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_q, high_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;
    logic         locked_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_cap_d = high_cap_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;

        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            high_cap_d = '0;
            timeout_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d      = ONE_W;
                        high_cap_d = '0;
                        state_d    = MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the MAXCOUNT cycle still counts as a valid period.
                    if (rise) begin
                        period_d   = cnt_q;
                        high_d     = high_cap_q;
                        valid_d    = 1'b1;
                        timeout_d  = 1'b0;
                        cnt_d      = ONE_W;
                        high_cap_d = '0;
                    end else if (cnt_q == MAX_W) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + ONE_W;
                        if (fall) begin
                            high_cap_d = cnt_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_cap_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_cap_q <= high_cap_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            locked_q   <= (state_d == MEASURE);
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter against an edge-timestamp reference model.
module tb_clk_period_meter;

    localparam int unsigned MAXCOUNT = 100;
    localparam int unsigned SYNC     = 2;
    localparam int unsigned W        = $clog2(MAXCOUNT + 1);

    logic         clk = 1'b0;
    logic         rst, en, sig_in;
    logic [W-1:0] period, high_time;
    logic         period_valid, timeout, locked;

    always #5 clk = ~clk;

    clk_period_meter #(
        .MAXCOUNT   (MAXCOUNT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sig_in      (sig_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout),
        .locked      (locked)
    );

    typedef struct packed {
        logic         v;
        logic         l;
        logic         t;
        logic [W-1:0] p;
        logic [W-1:0] h;
    } exp_t;

    // Model results become visible on the outputs two ticks after the driven edge.
    exp_t dly[2];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_valid = 0;

    bit m_prev, m_locked, m_timeout, m_fall_seen;
    int m_ref, m_fall_t, m_period, m_high;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_prev      = 1'b0;
        m_locked    = 1'b0;
        m_timeout   = 1'b0;
        m_fall_seen = 1'b0;
        m_ref       = 0;
        m_fall_t    = 0;
        m_period    = 0;
        m_high      = 0;
        dly[0]      = '0;
        dly[1]      = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high"}, int'(high_time), 0);
        chk({tag, "_valid"}, int'(period_valid), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_locked"}, int'(locked), 0);
    endtask

    task automatic tick(input logic s);
        bit   r, f, res;
        exp_t cur;
        sig_in = s;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_clear();
            chk_all_zero("in_reset");
            return;
        end
        r      = s & ~m_prev;
        f      = ~s & m_prev;
        m_prev = s;
        res    = 1'b0;
        if (!en) begin
            m_locked  = 1'b0;
            m_timeout = 1'b0;
        end else if (m_locked) begin
            if (r) begin
                res         = 1'b1;
                m_period    = cyc - m_ref;
                m_high      = m_fall_seen ? (m_fall_t - m_ref) : 0;
                m_timeout   = 1'b0;
                m_ref       = cyc;
                m_fall_seen = 1'b0;
            end else begin
                if (f) begin
                    m_fall_seen = 1'b1;
                    m_fall_t    = cyc;
                end
                if (cyc - m_ref == int'(MAXCOUNT)) begin
                    m_locked  = 1'b0;
                    m_timeout = 1'b1;
                end
            end
        end else if (r) begin
            m_locked    = 1'b1;
            m_ref       = cyc;
            m_fall_seen = 1'b0;
        end
        cur.v = res;
        cur.l = m_locked;
        cur.t = m_timeout;
        cur.p = W'(m_period);
        cur.h = W'(m_high);
        // Disabling takes effect on the very next edge, not through the synchronizer.
        if (!en) begin
            for (int i = 0; i < 2; i++) begin
                dly[i].v = 1'b0;
                dly[i].l = 1'b0;
                dly[i].t = 1'b0;
            end
        end
        chk("period_valid", int'(period_valid), int'(dly[1].v));
        chk("locked", int'(locked), int'(dly[1].l));
        chk("timeout", int'(timeout), int'(dly[1].t));
        chk("period", int'(period), int'(dly[1].p));
        chk("high_time", int'(high_time), int'(dly[1].h));
        if (period_valid) n_valid++;
        dly[1] = dly[0];
        dly[0] = cur;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end
    endtask

    initial begin
        int n0, c, hi, lo;
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (3) tick(1'b0);

        // 10-cycle square wave, 5 high
        en = 1'b1;
        repeat (3) tick(1'b0);
        wave(5, 5, 4);
        chk("sq10_period", int'(period), 10);
        chk("sq10_high", int'(high_time), 5);
        chk("sq10_locked", int'(locked), 1);

        // Duty change to 3 high / 7 low
        n0 = n_valid;
        wave(3, 7, 3);
        chk("duty_period", int'(period), 10);
        chk("duty_high", int'(high_time), 3);
        chk("duty_valid_count", n_valid - n0, 3);

        // Random periods, some long enough to time out
        repeat (30) begin
            hi = int'($urandom_range(1, 45));
            lo = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 110))
                                            : int'($urandom_range(1, 45));
            wave(hi, lo, 1);
        end

        // Timeout latency from a fresh arm with sig_in stuck high
        repeat (4) tick(1'b0);
        en = 1'b0;
        repeat (4) tick(1'b0);
        en = 1'b1;
        repeat (4) tick(1'b0);
        c = cyc + 1;
        tick(1'b1);
        for (int i = 0; i < 200 && !timeout; i++) tick(1'b1);
        chk("timeout_latency", cyc - c, int'(MAXCOUNT) + SYNC);
        chk("timeout_unlocked", int'(locked), 0);
        chk("timeout_flag", int'(timeout), 1);
        repeat (3) tick(1'b0);
        wave(20, 20, 2);
        chk("after_to_period", int'(period), 40);
        chk("after_to_high", int'(high_time), 20);
        chk("after_to_cleared", int'(timeout), 0);

        // Rises exactly MAXCOUNT apart
        wave(50, 50, 3);
        chk("max_period", int'(period), int'(MAXCOUNT));
        chk("max_high", int'(high_time), 50);
        chk("max_no_timeout", int'(timeout), 0);

        // Enable dropped mid-period, then re-armed
        wave(6, 6, 2);
        repeat (4) tick(1'b1);
        en = 1'b0;
        n0 = n_valid;
        repeat (3) tick(1'b1);
        repeat (3) tick(1'b0);
        repeat (2) tick(1'b1);
        repeat (4) tick(1'b0);
        chk("en_off_no_valid", n_valid - n0, 0);
        chk("en_off_unlocked", int'(locked), 0);
        en = 1'b1;
        repeat (2) tick(1'b0);
        wave(4, 9, 2);
        repeat (4) tick(1'b0);
        chk("rearm_valid_count", n_valid - n0, 1);
        chk("rearm_period", int'(period), 13);
        chk("rearm_high", int'(high_time), 4);

        // Reset in the middle of a measurement
        wave(7, 5, 2);
        repeat (2) tick(1'b1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        n0 = n_valid;
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        rst = 1'b0;
        repeat (3) tick(1'b0);
        wave(8, 4, 3);
        repeat (3) tick(1'b0);
        chk("post_reset_valid_count", n_valid - n0, 2);
        chk("post_reset_period", int'(period), 12);
        chk("post_reset_high", int'(high_time), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
